// File: rtl/fill_tracker.sv
// Own-order fill tracker: matches exchange execute messages against our resting
// orders and emits one inventory update pulse per fill on our own order.
module fill_tracker #(
  parameter int NUM_STOCKS = 4,
  parameter int NUM_ORDERS = 8,
  parameter int DATA_WIDTH = 32,
  parameter int REF_WIDTH  = 64
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_add_valid,
  input  logic [REF_WIDTH-1:0]            i_add_ref,
  input  logic [$clog2(NUM_STOCKS)-1:0]   i_add_stock_id,
  input  logic                            i_add_side,
  input  logic [DATA_WIDTH-1:0]           i_add_qty,
  output logic                            o_add_ready,
  output logic                            o_add_reject,
  input  logic                            i_exec_valid,
  input  logic [REF_WIDTH-1:0]            i_exec_ref,
  input  logic [DATA_WIDTH-1:0]           i_exec_qty,
  output logic                            o_exec_ready,
  output logic                            o_execute_order,
  output logic [DATA_WIDTH-1:0]           o_execute_order_quantity,
  output logic                            o_execute_order_side,
  output logic [$clog2(NUM_STOCKS)-1:0]   o_stock_id,
  output logic                            o_overfill,
  output logic [15:0]                     o_miss_count,
  output logic [$clog2(NUM_ORDERS):0]     o_occupancy
);

  localparam int STOCK_W = $clog2(NUM_STOCKS);
  localparam int IDX_W   = $clog2(NUM_ORDERS);
  localparam int OCC_W   = IDX_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  logic [1:0]            r_state;
  logic [NUM_ORDERS-1:0] r_valid;
  logic [NUM_ORDERS-1:0] r_side;
  logic [REF_WIDTH-1:0]  r_ref   [NUM_ORDERS];
  logic [STOCK_W-1:0]    r_stock [NUM_ORDERS];
  logic [DATA_WIDTH-1:0] r_qty   [NUM_ORDERS];

  logic [REF_WIDTH-1:0]  r_exec_ref;
  logic [DATA_WIDTH-1:0] r_exec_qty;
  logic                  r_hit;
  logic [IDX_W-1:0]      r_hit_idx;

  logic                  w_add_dup;
  logic                  w_free_found;
  logic [IDX_W-1:0]      w_free_idx;
  logic                  w_lookup_hit;
  logic [IDX_W-1:0]      w_lookup_idx;
  logic [DATA_WIDTH-1:0] w_rem;
  logic [DATA_WIDTH-1:0] w_fill;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic                  w_over;
  logic                  w_exec_fire;
  logic                  w_add_fire;
  logic                  w_add_ok;

  assign o_exec_ready = i_reset_n && (r_state == S_IDLE);
  assign o_add_ready  = i_reset_n && (r_state == S_IDLE) && !i_exec_valid;
  assign w_exec_fire  = o_exec_ready && i_exec_valid;
  assign w_add_fire   = o_add_ready && i_add_valid;
  assign w_add_ok     = w_add_fire && w_free_found && !w_add_dup && (i_add_qty != '0);

  // Descending scans so the lowest matching / free index wins.
  always_comb begin
    w_add_dup    = 1'b0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_lookup_hit = 1'b0;
    w_lookup_idx = '0;
    for (int i = NUM_ORDERS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_ref[i] == i_add_ref)) w_add_dup = 1'b1;
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_valid[i] && (r_ref[i] == r_exec_ref)) begin
        w_lookup_hit = 1'b1;
        w_lookup_idx = IDX_W'(i);
      end
    end
  end

  // The fill is clamped to the remaining quantity so the write-back never underflows.
  assign w_rem      = r_qty[r_hit_idx];
  assign w_over     = r_exec_qty > w_rem;
  assign w_fill     = w_over ? w_rem : r_exec_qty;
  assign w_rem_next = w_rem - w_fill;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state                  <= S_IDLE;
      r_valid                  <= '0;
      r_exec_ref               <= '0;
      r_exec_qty               <= '0;
      r_hit                    <= 1'b0;
      r_hit_idx                <= '0;
      o_add_reject             <= 1'b0;
      o_execute_order          <= 1'b0;
      o_execute_order_quantity <= '0;
      o_execute_order_side     <= 1'b0;
      o_stock_id               <= '0;
      o_overfill               <= 1'b0;
      o_miss_count             <= '0;
      o_occupancy              <= '0;
    end else begin
      o_add_reject    <= 1'b0;
      o_execute_order <= 1'b0;
      o_overfill      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_exec_fire) begin
            r_exec_ref <= i_exec_ref;
            r_exec_qty <= i_exec_qty;
            r_state    <= S_LOOKUP;
          end else if (w_add_fire) begin
            if (w_add_ok) begin
              r_valid[w_free_idx] <= 1'b1;
              o_occupancy         <= o_occupancy + OCC_W'(1);
            end else begin
              o_add_reject <= 1'b1;
            end
          end
        end
        S_LOOKUP: begin
          r_hit     <= w_lookup_hit;
          r_hit_idx <= w_lookup_idx;
          r_state   <= S_UPDATE;
        end
        S_UPDATE: begin
          if (r_hit) begin
            o_execute_order          <= 1'b1;
            o_execute_order_quantity <= w_fill;
            o_execute_order_side     <= r_side[r_hit_idx];
            o_stock_id               <= r_stock[r_hit_idx];
            o_overfill               <= w_over;
            if (w_rem_next == '0) begin
              r_valid[r_hit_idx] <= 1'b0;
              o_occupancy        <= o_occupancy - OCC_W'(1);
            end
          end else if (o_miss_count != 16'hFFFF) begin
            o_miss_count <= o_miss_count + 16'd1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Entry payload needs no reset: the valid bits alone decide what is live.
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      if ((r_state == S_IDLE) && w_add_ok) begin
        r_ref[w_free_idx]   <= i_add_ref;
        r_stock[w_free_idx] <= i_add_stock_id;
        r_side[w_free_idx]  <= i_add_side;
        r_qty[w_free_idx]   <= i_add_qty;
      end else if ((r_state == S_UPDATE) && r_hit) begin
        r_qty[r_hit_idx] <= w_rem_next;
      end
    end
  end

endmodule

// File: tb/tb_fill_tracker.sv
// Directed testbench for fill_tracker: per-scenario tasks with hand-computed
// expectations for fills, rejects, arbitration and mid-operation reset.
module tb_fill_tracker;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_add_valid = 1'b0;
  logic [63:0] i_add_ref = '0;
  logic [1:0]  i_add_stock_id = '0;
  logic        i_add_side = 1'b0;
  logic [31:0] i_add_qty = '0;
  logic        o_add_ready;
  logic        o_add_reject;
  logic        i_exec_valid = 1'b0;
  logic [63:0] i_exec_ref = '0;
  logic [31:0] i_exec_qty = '0;
  logic        o_exec_ready;
  logic        o_execute_order;
  logic [31:0] o_execute_order_quantity;
  logic        o_execute_order_side;
  logic [1:0]  o_stock_id;
  logic        o_overfill;
  logic [15:0] o_miss_count;
  logic [3:0]  o_occupancy;

  int vectors = 0;
  int miscompares = 0;
  int exp_miss = 0;

  fill_tracker #(.NUM_STOCKS(4), .NUM_ORDERS(8), .DATA_WIDTH(32), .REF_WIDTH(64)) dut (
    .i_clk                    (clk),
    .i_reset_n                (i_reset_n),
    .i_add_valid              (i_add_valid),
    .i_add_ref                (i_add_ref),
    .i_add_stock_id           (i_add_stock_id),
    .i_add_side               (i_add_side),
    .i_add_qty                (i_add_qty),
    .o_add_ready              (o_add_ready),
    .o_add_reject             (o_add_reject),
    .i_exec_valid             (i_exec_valid),
    .i_exec_ref               (i_exec_ref),
    .i_exec_qty               (i_exec_qty),
    .o_exec_ready             (o_exec_ready),
    .o_execute_order          (o_execute_order),
    .o_execute_order_quantity (o_execute_order_quantity),
    .o_execute_order_side     (o_execute_order_side),
    .o_stock_id               (o_stock_id),
    .o_overfill               (o_overfill),
    .o_miss_count             (o_miss_count),
    .o_occupancy              (o_occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present an add for exactly one rising edge; returns 1ns after that edge.
  task automatic drive_add(input logic [63:0] r, input logic [1:0] s, input logic sd,
                           input logic [31:0] q, output logic rdy);
    @(negedge clk);
    i_add_valid = 1'b1; i_add_ref = r; i_add_stock_id = s; i_add_side = sd; i_add_qty = q;
    #1 rdy = o_add_ready;
    @(posedge clk);
    #1 i_add_valid = 1'b0;
  endtask

  // Present an exec, then step through LOOKUP and UPDATE; returns 1ns after the
  // edge that should raise the fill pulse.
  task automatic drive_exec(input logic [63:0] r, input logic [31:0] q,
                            output logic early, output logic busy);
    @(negedge clk);
    i_exec_valid = 1'b1; i_exec_ref = r; i_exec_qty = q;
    @(posedge clk);
    #1 i_exec_valid = 1'b0;
    early = o_execute_order;
    busy  = o_exec_ready | o_add_ready;
    @(posedge clk);
    #1 early = early | o_execute_order;
    busy = busy | o_exec_ready | o_add_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (o_exec_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_exec_ready: got %0b exp 0", o_exec_ready); end
    vectors++; if (o_add_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_add_ready: got %0b exp 0", o_add_ready); end
    vectors++; if (o_occupancy !== 4'd0) begin miscompares++; $display("[TB] FAIL rst_occ: got %0d exp 0", o_occupancy); end
    vectors++; if (o_miss_count !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_miss: got %0d exp 0", o_miss_count); end
    vectors++; if (o_execute_order !== 1'b0 || o_execute_order_quantity !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_exec_out: got %0b/%0d exp 0/0", o_execute_order, o_execute_order_quantity); end
    vectors++; if (o_add_reject !== 1'b0 || o_overfill !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pulses: got %0b/%0b exp 0/0", o_add_reject, o_overfill); end
    @(negedge clk);
    i_reset_n = 1'b1;
    #1;
    vectors++; if (o_exec_ready !== 1'b1 || o_add_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_release_ready: got %0b/%0b exp 1/1", o_exec_ready, o_add_ready); end
  endtask

  task automatic test_full_fill();
    logic rdy, early, busy;
    drive_add(64'h1234, 2'd2, 1'b0, 32'd100, rdy);
    vectors++; if (rdy !== 1'b1 || o_add_reject !== 1'b0) begin miscompares++; $display("[TB] FAIL ff_add: got rdy %0b rej %0b exp 1/0", rdy, o_add_reject); end
    vectors++; if (o_occupancy !== 4'd1) begin miscompares++; $display("[TB] FAIL ff_occ1: got %0d exp 1", o_occupancy); end
    drive_exec(64'h1234, 32'd100, early, busy);
    vectors++; if (early !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ff_busy: got early %0b busy %0b exp 0/0", early, busy); end
    vectors++; if (o_execute_order !== 1'b1) begin miscompares++; $display("[TB] FAIL ff_pulse: got %0b exp 1", o_execute_order); end
    vectors++; if (o_execute_order_quantity !== 32'd100 || o_execute_order_side !== 1'b0 || o_stock_id !== 2'd2) begin miscompares++; $display("[TB] FAIL ff_data: got q %0d side %0b stk %0d exp 100/0/2", o_execute_order_quantity, o_execute_order_side, o_stock_id); end
    vectors++; if (o_overfill !== 1'b0) begin miscompares++; $display("[TB] FAIL ff_overfill: got %0b exp 0", o_overfill); end
    vectors++; if (o_occupancy !== 4'd0) begin miscompares++; $display("[TB] FAIL ff_occ0: got %0d exp 0", o_occupancy); end
    @(posedge clk);
    #1;
    vectors++; if (o_execute_order !== 1'b0 || o_execute_order_quantity !== 32'd100) begin miscompares++; $display("[TB] FAIL ff_hold: got %0b/%0d exp 0/100", o_execute_order, o_execute_order_quantity); end
  endtask

  task automatic test_partial_fill();
    logic rdy, early, busy;
    drive_add(64'hA, 2'd1, 1'b1, 32'd50, rdy);
    vectors++; if (o_add_reject !== 1'b0 || o_occupancy !== 4'd1) begin miscompares++; $display("[TB] FAIL pf_add: got rej %0b occ %0d exp 0/1", o_add_reject, o_occupancy); end
    drive_exec(64'hA, 32'd20, early, busy);
    vectors++; if (o_execute_order !== 1'b1 || o_execute_order_quantity !== 32'd20 || o_execute_order_side !== 1'b1 || o_stock_id !== 2'd1) begin miscompares++; $display("[TB] FAIL pf_first: got p %0b q %0d side %0b stk %0d exp 1/20/1/1", o_execute_order, o_execute_order_quantity, o_execute_order_side, o_stock_id); end
    vectors++; if (o_occupancy !== 4'd1) begin miscompares++; $display("[TB] FAIL pf_occ_keep: got %0d exp 1", o_occupancy); end
    drive_exec(64'hA, 32'd30, early, busy);
    vectors++; if (o_execute_order !== 1'b1 || o_execute_order_quantity !== 32'd30 || o_overfill !== 1'b0) begin miscompares++; $display("[TB] FAIL pf_second: got p %0b q %0d ovf %0b exp 1/30/0", o_execute_order, o_execute_order_quantity, o_overfill); end
    vectors++; if (o_occupancy !== 4'd0) begin miscompares++; $display("[TB] FAIL pf_occ_free: got %0d exp 0", o_occupancy); end
    drive_exec(64'hA, 32'd5, early, busy);
    exp_miss++;
    vectors++; if (o_execute_order !== 1'b0 || early !== 1'b0) begin miscompares++; $display("[TB] FAIL pf_miss_pulse: got %0b/%0b exp 0/0", o_execute_order, early); end
    vectors++; if (o_miss_count !== 16'(exp_miss)) begin miscompares++; $display("[TB] FAIL pf_miss_count: got %0d exp %0d", o_miss_count, exp_miss); end
  endtask

  task automatic test_overfill();
    logic rdy, early, busy;
    drive_add(64'hB, 2'd3, 1'b0, 32'd10, rdy);
    drive_exec(64'hB, 32'd25, early, busy);
    vectors++; if (o_execute_order !== 1'b1 || o_execute_order_quantity !== 32'd10 || o_stock_id !== 2'd3) begin miscompares++; $display("[TB] FAIL of_pulse: got p %0b q %0d stk %0d exp 1/10/3", o_execute_order, o_execute_order_quantity, o_stock_id); end
    vectors++; if (o_overfill !== 1'b1) begin miscompares++; $display("[TB] FAIL of_flag: got %0b exp 1", o_overfill); end
    vectors++; if (o_occupancy !== 4'd0) begin miscompares++; $display("[TB] FAIL of_occ: got %0d exp 0", o_occupancy); end
    @(posedge clk);
    #1;
    vectors++; if (o_overfill !== 1'b0) begin miscompares++; $display("[TB] FAIL of_flag_drop: got %0b exp 0", o_overfill); end
  endtask

  task automatic test_zero_qty();
    logic rdy, early, busy;
    drive_add(64'hF0, 2'd0, 1'b0, 32'd0, rdy);
    vectors++; if (o_add_reject !== 1'b1 || o_occupancy !== 4'd0) begin miscompares++; $display("[TB] FAIL zq_add_reject: got rej %0b occ %0d exp 1/0", o_add_reject, o_occupancy); end
    drive_add(64'hC, 2'd0, 1'b1, 32'd7, rdy);
    drive_exec(64'hC, 32'd0, early, busy);
    vectors++; if (o_execute_order !== 1'b1 || o_execute_order_quantity !== 32'd0 || o_overfill !== 1'b0) begin miscompares++; $display("[TB] FAIL zq_exec0: got p %0b q %0d ovf %0b exp 1/0/0", o_execute_order, o_execute_order_quantity, o_overfill); end
    vectors++; if (o_occupancy !== 4'd1) begin miscompares++; $display("[TB] FAIL zq_occ_keep: got %0d exp 1", o_occupancy); end
    drive_exec(64'hC, 32'd7, early, busy);
    vectors++; if (o_execute_order !== 1'b1 || o_execute_order_quantity !== 32'd7 || o_execute_order_side !== 1'b1) begin miscompares++; $display("[TB] FAIL zq_full: got p %0b q %0d side %0b exp 1/7/1", o_execute_order, o_execute_order_quantity, o_execute_order_side); end
    vectors++; if (o_occupancy !== 4'd0) begin miscompares++; $display("[TB] FAIL zq_occ_free: got %0d exp 0", o_occupancy); end
  endtask

  task automatic test_priority();
    logic early, busy;
    @(negedge clk);
    i_add_valid = 1'b1; i_add_ref = 64'hD; i_add_stock_id = 2'd2; i_add_side = 1'b1; i_add_qty = 32'd40;
    i_exec_valid = 1'b1; i_exec_ref = 64'hEEEE; i_exec_qty = 32'd1;
    #1;
    vectors++; if (o_add_ready !== 1'b0 || o_exec_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL pr_arb: got add %0b exec %0b exp 0/1", o_add_ready, o_exec_ready); end
    @(posedge clk);
    #1 i_exec_valid = 1'b0;
    vectors++; if (o_add_ready !== 1'b0 || o_exec_ready !== 1'b0 || o_occupancy !== 4'd0) begin miscompares++; $display("[TB] FAIL pr_lookup: got add %0b exec %0b occ %0d exp 0/0/0", o_add_ready, o_exec_ready, o_occupancy); end
    @(posedge clk);
    #1;
    vectors++; if (o_add_ready !== 1'b0 || o_exec_ready !== 1'b0 || o_occupancy !== 4'd0) begin miscompares++; $display("[TB] FAIL pr_update: got add %0b exec %0b occ %0d exp 0/0/0", o_add_ready, o_exec_ready, o_occupancy); end
    @(posedge clk);
    #1;
    exp_miss++;
    vectors++; if (o_execute_order !== 1'b0 || o_miss_count !== 16'(exp_miss)) begin miscompares++; $display("[TB] FAIL pr_miss: got p %0b miss %0d exp 0/%0d", o_execute_order, o_miss_count, exp_miss); end
    vectors++; if (o_add_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL pr_idle_ready: got %0b exp 1", o_add_ready); end
    @(posedge clk);
    #1 i_add_valid = 1'b0;
    vectors++; if (o_occupancy !== 4'd1 || o_add_reject !== 1'b0) begin miscompares++; $display("[TB] FAIL pr_add_late: got occ %0d rej %0b exp 1/0", o_occupancy, o_add_reject); end
    drive_exec(64'hD, 32'd40, early, busy);
    vectors++; if (o_execute_order !== 1'b1 || o_execute_order_quantity !== 32'd40 || o_stock_id !== 2'd2 || o_occupancy !== 4'd0) begin miscompares++; $display("[TB] FAIL pr_fill: got p %0b q %0d stk %0d occ %0d exp 1/40/2/0", o_execute_order, o_execute_order_quantity, o_stock_id, o_occupancy); end
  endtask

  task automatic test_table_full();
    logic rdy, early, busy;
    for (int i = 0; i < 8; i++) begin
      drive_add(64'h100 + 64'(i), 2'(i % 4), 1'(i % 2), 32'(10 + i), rdy);
      vectors++; if (o_add_reject !== 1'b0 || o_occupancy !== 4'(i + 1)) begin miscompares++; $display("[TB] FAIL tf_add%0d: got rej %0b occ %0d exp 0/%0d", i, o_add_reject, o_occupancy, i + 1); end
    end
    drive_add(64'h200, 2'd0, 1'b0, 32'd9, rdy);
    vectors++; if (rdy !== 1'b1 || o_add_reject !== 1'b1 || o_occupancy !== 4'd8) begin miscompares++; $display("[TB] FAIL tf_ninth: got rdy %0b rej %0b occ %0d exp 1/1/8", rdy, o_add_reject, o_occupancy); end
    drive_exec(64'h103, 32'd13, early, busy);
    vectors++; if (o_execute_order !== 1'b1 || o_execute_order_quantity !== 32'd13 || o_execute_order_side !== 1'b1 || o_stock_id !== 2'd3) begin miscompares++; $display("[TB] FAIL tf_fill3: got p %0b q %0d side %0b stk %0d exp 1/13/1/3", o_execute_order, o_execute_order_quantity, o_execute_order_side, o_stock_id); end
    vectors++; if (o_occupancy !== 4'd7) begin miscompares++; $display("[TB] FAIL tf_occ7: got %0d exp 7", o_occupancy); end
    drive_add(64'h105, 2'd1, 1'b0, 32'd3, rdy);
    vectors++; if (o_add_reject !== 1'b1 || o_occupancy !== 4'd7) begin miscompares++; $display("[TB] FAIL tf_dup: got rej %0b occ %0d exp 1/7", o_add_reject, o_occupancy); end
    drive_add(64'h300, 2'd0, 1'b0, 32'd5, rdy);
    vectors++; if (o_add_reject !== 1'b0 || o_occupancy !== 4'd8) begin miscompares++; $display("[TB] FAIL tf_reuse: got rej %0b occ %0d exp 0/8", o_add_reject, o_occupancy); end
    drive_exec(64'h300, 32'd5, early, busy);
    vectors++; if (o_execute_order !== 1'b1 || o_execute_order_quantity !== 32'd5 || o_execute_order_side !== 1'b0 || o_stock_id !== 2'd0) begin miscompares++; $display("[TB] FAIL tf_reuse_fill: got p %0b q %0d side %0b stk %0d exp 1/5/0/0", o_execute_order, o_execute_order_quantity, o_execute_order_side, o_stock_id); end
  endtask

  task automatic test_reset_mid();
    logic early, busy;
    @(negedge clk);
    i_exec_valid = 1'b1; i_exec_ref = 64'h101; i_exec_qty = 32'd1;
    @(posedge clk);
    #1 i_exec_valid = 1'b0;
    i_reset_n = 1'b0;
    vectors++; if (o_exec_ready !== 1'b0 || o_add_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_ready: got %0b/%0b exp 0/0", o_exec_ready, o_add_ready); end
    @(posedge clk);
    #1;
    exp_miss = 0;
    vectors++; if (o_execute_order !== 1'b0 || o_occupancy !== 4'd0 || o_miss_count !== 16'd0) begin miscompares++; $display("[TB] FAIL rm_cleared: got p %0b occ %0d miss %0d exp 0/0/0", o_execute_order, o_occupancy, o_miss_count); end
    vectors++; if (o_execute_order_quantity !== 32'd0 || o_stock_id !== 2'd0) begin miscompares++; $display("[TB] FAIL rm_outs: got q %0d stk %0d exp 0/0", o_execute_order_quantity, o_stock_id); end
    @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (o_execute_order !== 1'b0 || o_exec_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_idle: got p %0b rdy %0b exp 0/1", o_execute_order, o_exec_ready); end
    drive_exec(64'h101, 32'd1, early, busy);
    exp_miss++;
    vectors++; if (o_execute_order !== 1'b0 || o_miss_count !== 16'(exp_miss)) begin miscompares++; $display("[TB] FAIL rm_old_ref: got p %0b miss %0d exp 0/%0d", o_execute_order, o_miss_count, exp_miss); end
  endtask

  initial begin
    $display("[TB] starting fill_tracker directed tests");
    test_reset();
    test_full_fill();
    test_partial_fill();
    test_overfill();
    test_zero_qty();
    test_priority();
    test_table_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fill_tracker.md
Name: fill_tracker

Overview:
- Write-side producer for the per-stock normalised inventory store.
- Holds a table of our own resting orders: reference, stock, side and remaining quantity.
- Consumes decoded exchange execute messages, matches each one against the table and decrements the remaining quantity.
- For every fill on our own order, emits a single-cycle execute pulse with stock id, side and filled quantity, which drives the inventory update port directly.

Parameters:
- NUM_STOCKS, 4, number of instruments; stock id width is $clog2(NUM_STOCKS).
- NUM_ORDERS, 8, own-order table depth.
- DATA_WIDTH, 32, share quantity width.
- REF_WIDTH, 64, exchange order reference width.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_add_valid  in  1  request to register a newly placed own order.
- i_add_ref  in  REF_WIDTH  order reference of the new order.
- i_add_stock_id  in  $clog2(NUM_STOCKS)  stock of the new order.
- i_add_side  in  1  side of the new order: 0 buy, 1 sell.
- i_add_qty  in  DATA_WIDTH  initial quantity of the new order.
- o_add_ready  out  1  add request accepted this cycle.
- o_add_reject  out  1  one-cycle pulse: add dropped because the table is full, the reference is a duplicate, or the quantity is zero.
- i_exec_valid  in  1  decoded exchange execute message present.
- i_exec_ref  in  REF_WIDTH  reference of the executed order.
- i_exec_qty  in  DATA_WIDTH  executed shares.
- o_exec_ready  out  1  execute message accepted this cycle.
- o_execute_order  out  1  one-cycle fill pulse to the inventory.
- o_execute_order_quantity  out  DATA_WIDTH  filled shares.
- o_execute_order_side  out  1  side of the filled own order: 0 buy (inventory up), 1 sell (inventory down).
- o_stock_id  out  $clog2(NUM_STOCKS)  stock of the fill.
- o_overfill  out  1  one-cycle pulse, coincident with the fill pulse, when i_exec_qty exceeded the remaining quantity.
- o_miss_count  out  16  saturating count of execute messages that match no own order.
- o_occupancy  out  $clog2(NUM_ORDERS)+1  number of valid table entries.

Behaviour:
Reset:
- i_reset_n low at a rising edge clears all valid bits, returns the FSM to IDLE, and zeroes every registered output, o_miss_count and o_occupancy.
- While i_reset_n is low, o_add_ready and o_exec_ready are driven 0.
- A reset during LOOKUP or UPDATE abandons the message: no fill pulse and no table write.

FSM states:
- IDLE:
  - o_exec_ready = 1.
  - o_add_ready = !i_exec_valid; execute has priority over add.
  - An accepted exec captures ref and qty, then goes to LOOKUP.
- LOOKUP (1 cycle):
  - Parallel compare of the captured ref against all valid entries.
  - Registers the hit flag and the lowest matching index.
  - Goes to UPDATE.
- UPDATE (1 cycle):
  - On a hit, let rem be the entry's remaining quantity and fill = min(qty, rem).
  - Assert o_execute_order; drive quantity = fill, side and stock from the entry.
  - Assert o_overfill if qty > rem.
  - Write rem - fill back to the entry; clear its valid bit when the result is 0.
  - On a miss: no pulse; o_miss_count increments, saturating at 0xFFFF.
  - Returns to IDLE.
- LOOKUP and UPDATE drive both ready outputs 0.

Latency and throughput:
- Exec accept at edge N gives a fill pulse during the cycle after edge N+2.
- Sustained throughput is one exec per 3 cycles.

Execute outputs:
- o_execute_order_quantity, _side and o_stock_id are registered.
- They hold their last value when no pulse is active.
- A qty of 0 on a hit still produces a pulse with quantity 0 and leaves the entry unchanged.

Add (single cycle, in IDLE on acceptance):
- Reject with o_add_reject on the next cycle if:
  - the table is full, or
  - the ref matches a valid entry, or
  - i_add_qty == 0.
- Otherwise write the lowest-index free slot on the accepting edge.
- o_occupancy updates on the same edge as the write.
- A slot freed in UPDATE is reusable by an add on the following IDLE cycle.

Arithmetic:
- All quantities are unsigned DATA_WIDTH; no wrap.
- rem - fill is never negative because of the clamp.

Test Plan:
- Full fill: add ref 0x1234 (stock 2, buy, qty 100), then exec 0x1234 qty 100 → one pulse 3 cycles after accept with qty 100, side 0, stock 2; o_occupancy goes 1 → 0.
- Partial fills: add ref 0xA (stock 1, sell, qty 50); exec 0xA qty 20 → pulse qty 20, side 1; exec 0xA qty 30 → pulse qty 30; entry freed; a third exec on 0xA → no pulse, o_miss_count = 1.
- Overfill: add qty 10, exec qty 25 → pulse qty 10 with o_overfill high, entry freed.
- Table full and duplicate: 8 adds with distinct refs all accepted, o_occupancy = 8; ninth add → o_add_reject; re-add of an existing ref after one entry frees → o_add_reject.
- Priority and handshake: i_add_valid and i_exec_valid high together in IDLE → exec accepted, o_add_ready 0; add accepted on the first IDLE cycle after UPDATE; both readys 0 in LOOKUP and UPDATE.
- Reset mid-operation: assert i_reset_n = 0 during LOOKUP → no fill pulse, occupancy 0, FSM in IDLE; the next exec on the old ref → miss.
